// File: rtl/mccoy_core_p_if.sv
// Instruction handshake and architectural status bundle for the McCoy core.
// The master side feeds instructions; the slave side is the core itself.
interface mccoy_core_p_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
);
    logic [5:0]        instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] x8;
    logic              carry;
    logic              halted;
    logic              retired;

    modport master (
        output instr, instr_valid,
        input  instr_ready, pc, x8, carry, halted, retired
    );

    modport slave (
        input  instr, instr_valid,
        output instr_ready, pc, x8, carry, halted, retired
    );
endinterface

// File: rtl/mccoy_core_p.sv
// Parametrised single-issue McCoy accumulator core with valid/ready
// instruction intake, carry flag, small register file and a HALT state.
module mccoy_core_p #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8,
    parameter int NREGS  = 8
) (
    input  logic            clk,
    input  logic            reset,
    mccoy_core_p_if.slave   io_bus
);
    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic { ST_RUN, ST_HALT } state_t;
    typedef enum logic [2:0] {
        OP_ADD, OP_ADDI, OP_LD, OP_ST, OP_LI, OP_BEZ, OP_JA, OP_SYS
    } op_t;

    state_t             r_state, w_stateNext;
    logic [PC_W-1:0]    r_pc, w_pcNext;
    logic [DATA_W-1:0]  r_x8, w_x8Next;
    logic               r_carry, w_carryNext;
    logic               r_retired, w_retiredNext;
    logic [DATA_W-1:0]  r_regs [NREGS];

    op_t                w_op;
    logic [2:0]         w_field;
    logic signed [2:0]  w_fieldS;
    logic [3:0]         w_mod;
    logic [IDX_W-1:0]   w_idx;
    logic [DATA_W-1:0]  w_regVal;
    logic [DATA_W-1:0]  w_imm;
    logic [DATA_W-1:0]  w_opB;
    logic [DATA_W:0]    w_sum;
    logic [PC_W-1:0]    w_off;
    logic               w_accept;
    logic               w_we;

    assign w_op     = op_t'(io_bus.instr[2:0]);
    assign w_field  = io_bus.instr[5:3];
    assign w_fieldS = w_field;
    assign w_mod    = {1'b0, w_field} % 4'(NREGS);
    assign w_idx    = IDX_W'(w_mod);
    assign w_regVal = r_regs[w_idx];
    assign w_imm    = DATA_W'(w_field);
    assign w_off    = PC_W'(w_fieldS);
    assign w_opB    = (w_op == OP_ADD) ? w_regVal : w_imm;
    assign w_sum    = {1'b0, r_x8} + {1'b0, w_opB};
    assign w_accept = io_bus.instr_valid && (r_state == ST_RUN);

    always_comb begin
        w_stateNext   = r_state;
        w_pcNext      = r_pc;
        w_x8Next      = r_x8;
        w_carryNext   = r_carry;
        w_retiredNext = 1'b0;
        w_we          = 1'b0;
        if (w_accept) begin
            w_retiredNext = 1'b1;
            w_pcNext      = r_pc + 1'b1;
            case (w_op)
                OP_ADD, OP_ADDI: {w_carryNext, w_x8Next} = w_sum;
                OP_LD:           w_x8Next = w_regVal;
                OP_ST:           w_we = 1'b1;
                OP_LI:           w_x8Next = w_imm;
                OP_BEZ: begin
                    if (r_x8 == '0) w_pcNext = r_pc + w_off;
                end
                OP_JA:           w_pcNext = PC_W'(r_x8);
                OP_SYS: begin
                    // Operand selects the system function; unused codes are NOPs.
                    case (w_field)
                        3'd0: begin
                            w_x8Next    = r_x8 - 1'b1;
                            w_carryNext = (r_x8 != '0);
                        end
                        3'd1:    w_carryNext = 1'b0;
                        3'd7:    w_stateNext = ST_HALT;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_RUN;
            r_pc      <= '0;
            r_x8      <= '0;
            r_carry   <= 1'b0;
            r_retired <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_pc      <= w_pcNext;
            r_x8      <= w_x8Next;
            r_carry   <= w_carryNext;
            r_retired <= w_retiredNext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_we) begin
            r_regs[w_idx] <= r_x8;
        end
    end

    assign io_bus.pc          = r_pc;
    assign io_bus.x8          = r_x8;
    assign io_bus.carry       = r_carry;
    assign io_bus.halted      = (r_state == ST_HALT);
    assign io_bus.retired     = r_retired;
    assign io_bus.instr_ready = (r_state != ST_HALT);
endmodule
